alu_muldiv: RTL and testbench

- Multi-cycle RV64M multiply/divide unit in the execute stage, beside the single-cycle ALU.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the word variants MULW/DIVW/DIVUW/REMW/REMUW.
- Handshakes with the pipeline through valid/ready on both sides.
- Stalls the pipeline while busy and accepts a flush for squashed instructions.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/div_iter.sv | 49 ++++
 rtl/alu_muldiv.sv | 210 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV64M multiply/divide unit.
package muldiv_pkg;

  localparam int MD_XLEN  = 64;
  localparam int MD_WLEN  = 32;
  localparam int MD_CNT_W = $clog2(MD_XLEN) + 1;

  typedef enum logic [3:0] {
    MD_MUL    = 4'd0,
    MD_MULH   = 4'd1,
    MD_MULHSU = 4'd2,
    MD_MULHU  = 4'd3,
    MD_DIV    = 4'd4,
    MD_DIVU   = 4'd5,
    MD_REM    = 4'd6,
    MD_REMU   = 4'd7
  } mdfunc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_iter.sv
// Restoring-division datapath on unsigned magnitudes, one quotient bit per step.
// Word operations pre-align the dividend into the top WLEN bits so that
// WLEN steps leave the quotient in the low WLEN bits.
module div_iter #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            is_32,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // Trial subtraction of the divisor from the shifted partial remainder.
  // When ge holds, the true difference is below the divisor, so the low
  // XLEN bits of the modular difference are exact.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted[XLEN-1:0] - dvs;
    ge      = (shifted >= {1'b0, dvs});
  end

  // Remainder/quotient registers: load on accept, one restoring step per enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      dvs <= divisor;
      quo <= is_32 ? {dividend[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : dividend;
    end else if (step) begin
      quo <= {quo[XLEN-2:0], ge};
      rem <= ge ? diff : shifted[XLEN-1:0];
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle RV64M multiply/divide unit with valid/ready on both sides.
// Optional build macro ALU_MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// combinational multiplier; divides stay iterative.
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | iterating, one radix-2 step per cycle
// DONE  | result held on c until out_ready or flush
module alu_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN,
  parameter int WLEN = MD_WLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  mdfunc_t         mdfunc,
  input  logic            is_32instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] c,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_t            state, state_nxt;
  logic              accept, step;
  logic [CNT_W-1:0]  cnt;

  logic              a_sgn_en, b_sgn_en, is_div_in, is_sdiv_in;
  logic [WLEN-1:0]   a_w, b_w;
  logic [XLEN-1:0]   a_ext, a_mag, b_mag;
  logic              a_neg, b_neg;
  logic              b_zero, a_min, b_m1, dz_in, ov_in, fast_mul_in;

  mdfunc_t           op_q;
  logic              w_q, a_neg_q, b_neg_q, dz_q, ov_q;
  logic [XLEN-1:0]   a_ext_q;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   mplier;

  logic [XLEN-1:0]   quo, rem;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   quo_s, rem_s, res, res_fmt;

  // Operation class and operand signedness from the request.
  always_comb begin
    a_sgn_en   = 1'b0;
    b_sgn_en   = 1'b0;
    is_div_in  = 1'b0;
    is_sdiv_in = 1'b0;
    case (mdfunc)
      MD_MULH:   begin a_sgn_en = 1'b1; b_sgn_en = 1'b1; end
      MD_MULHSU: a_sgn_en = 1'b1;
      MD_DIV, MD_REM: begin
        is_div_in  = 1'b1;
        is_sdiv_in = 1'b1;
        a_sgn_en   = 1'b1;
        b_sgn_en   = 1'b1;
      end
      MD_DIVU, MD_REMU: is_div_in = 1'b1;
      default: ;
    endcase
  end

  // Operand magnitudes, signs and divide special-case detection at the active width.
  always_comb begin
    a_w = a[WLEN-1:0];
    b_w = b[WLEN-1:0];
    if (is_32instr) begin
      a_neg  = a_sgn_en & a_w[WLEN-1];
      b_neg  = b_sgn_en & b_w[WLEN-1];
      a_ext  = {{(XLEN-WLEN){a_w[WLEN-1]}}, a_w};
      a_mag  = {{(XLEN-WLEN){1'b0}}, (a_neg ? -a_w : a_w)};
      b_mag  = {{(XLEN-WLEN){1'b0}}, (b_neg ? -b_w : b_w)};
      b_zero = (b_w == '0);
      a_min  = (a_w == {1'b1, {(WLEN-1){1'b0}}});
      b_m1   = &b_w;
    end else begin
      a_neg  = a_sgn_en & a[XLEN-1];
      b_neg  = b_sgn_en & b[XLEN-1];
      a_ext  = a;
      a_mag  = a_neg ? -a : a;
      b_mag  = b_neg ? -b : b;
      b_zero = (b == '0);
      a_min  = (a == {1'b1, {(XLEN-1){1'b0}}});
      b_m1   = &b;
    end
    dz_in = is_div_in & b_zero;
    ov_in = is_sdiv_in & a_min & b_m1;
  end

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_mul_in = (mdfunc == MD_MUL) || (mdfunc == MD_MULH) ||
                       (mdfunc == MD_MULHSU) || (mdfunc == MD_MULHU);
  assign fast_prod   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`else
  assign fast_mul_in = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; flush wins over a new request and over out_ready.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: if (in_valid && !flush) begin
        accept    = 1'b1;
        state_nxt = (dz_in || ov_in || fast_mul_in) ? DONE : BUSY;
      end
      BUSY: if (flush) begin
        state_nxt = IDLE;
      end else begin
        step = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: if (flush || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, step down-counter and shift-add multiplier.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q    <= MD_MUL;
      w_q     <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      a_ext_q <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (accept) begin
      op_q    <= mdfunc;
      w_q     <= is_32instr;
      a_neg_q <= a_neg;
      b_neg_q <= b_neg;
      dz_q    <= dz_in;
      ov_q    <= ov_in;
      a_ext_q <= a_ext;
      cnt     <= is_32instr ? CNT_W'(WLEN) : CNT_W'(XLEN);
      mcand   <= {{XLEN{1'b0}}, a_mag};
      mplier  <= b_mag;
`ifdef ALU_MULDIV_FAST_MUL_EN
      acc     <= fast_mul_in ? fast_prod : '0;
`else
      acc     <= '0;
`endif
    end else if (step) begin
      cnt    <= cnt - CNT_W'(1);
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  div_iter #(
    .XLEN (XLEN),
    .WLEN (WLEN)
  ) u_div_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (step),
    .is_32    (is_32instr),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo      (quo),
    .rem      (rem)
  );

  // Sign correction of magnitude results and per-operation result select.
  always_comb begin
    mul_prod = (a_neg_q ^ b_neg_q) ? -acc : acc;
    quo_s    = (a_neg_q ^ b_neg_q) ? -quo : quo;
    rem_s    = a_neg_q ? -rem : rem;
    res      = '0;
    case (op_q)
      MD_MUL: res = mul_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:
        res = w_q ? XLEN'(mul_prod[2*WLEN-1:WLEN]) : mul_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU: res = dz_q ? '1 : (ov_q ? a_ext_q : quo_s);
      MD_REM, MD_REMU: res = dz_q ? a_ext_q : (ov_q ? '0 : rem_s);
      default: res = '0;
    endcase
    res_fmt = w_q ? {{(XLEN-WLEN){res[WLEN-1]}}, res[WLEN-1:0]} : res;
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign c         = (state == DONE) ? res_fmt : '0;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv. Latency is counted in rising edges
// from the accept edge (which counts as 1) to the first edge after which
// out_valid is high.
module tb_alu_muldiv;
  import muldiv_pkg::*;

`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT_D = 1;
  localparam int MUL_LAT_W = 1;
`else
  localparam int MUL_LAT_D = 65;
  localparam int MUL_LAT_W = 33;
`endif
  localparam int LAT_D  = 65;
  localparam int LAT_W  = 33;
  localparam int LAT_SP = 1;

  logic        clk, reset, in_valid, in_ready, is_32instr, flush;
  logic        out_valid, out_ready, busy;
  logic [63:0] a, b, c;
  mdfunc_t     md;

  int n_tests = 0;
  int n_fail  = 0;

  alu_muldiv dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .mdfunc     (md),
    .is_32instr (is_32instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c          (c),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency, hold the result for 'hold' cycles,
  // then complete the handshake and confirm the unit returns to IDLE.
  task automatic run_op(input string tag, input mdfunc_t op, input logic w,
                        input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] exp_c, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; md = op; is_32instr = w; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_c"}, c, exp_c);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_c"}, c, exp_c);
      check({tag, "_hold_v"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_v"}, 64'(out_valid), 64'd0);
    check({tag, "_post_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int seen;
    reset = 1'b0; in_valid = 1'b0; is_32instr = 1'b0; flush = 1'b0;
    out_ready = 1'b0; a = '0; b = '0; md = MD_MUL;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_c", c, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;

    // Multiplies
    run_op("mul_7x-3", MD_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT_D, 5);
    run_op("mulhu_max", MD_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT_D, 0);
    run_op("mulhsu_-1x2", MD_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT_D, 0);
    run_op("mulh_-2x3", MD_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT_D, 0);
    run_op("mulh_2p62x4", MD_MULH, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, MUL_LAT_D, 0);
    run_op("mulw_sext", MD_MUL, 1'b1, 64'hDEAD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT_W, 0);

    // Divides, 64-bit
    run_op("div_-7/2", MD_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT_D, 0);
    run_op("rem_-7/2", MD_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT_D, 0);
    run_op("divu_max/3", MD_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, LAT_D, 0);
    run_op("remu_max/10", MD_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd5, LAT_D, 0);
    run_op("divu_by0", MD_DIVU, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LAT_SP, 2);
    run_op("rem_by0", MD_REM, 1'b0, 64'd5, 64'd0, 64'd5, LAT_SP, 0);
    run_op("div_ovf", MD_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, LAT_SP, 0);
    run_op("rem_ovf", MD_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, LAT_SP, 0);

    // Divides, word
    run_op("divw_ovf", MD_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, LAT_SP, 0);
    run_op("remuw_f/16", MD_REMU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'h0000_0000_0000_000F, LAT_W, 0);
    run_op("divuw_sext", MD_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, LAT_W, 0);
    run_op("remw_-7/2", MD_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT_W, 0);
    run_op("divw_upper", MD_DIV, 1'b1, 64'h1234_5678_0000_0064, 64'hABCD_0000_0000_0007, 64'h0000_0000_0000_000E, LAT_W, 0);

    // Undefined operation code completes with zero
    run_op("undef_op", mdfunc_t'(4'hF), 1'b0, 64'd9, 64'd9, 64'd0, LAT_D, 0);

    // Flush at cycle 10 of a DIV
    @(negedge clk);
    in_valid = 1'b1; md = MD_DIV; is_32instr = 1'b0; a = 64'd100; b = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_rdy", 64'(in_ready), 64'd1);
    check("flush_v", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_novalid", 64'(seen), 64'd0);
    run_op("mul_3x4", MD_MUL, 1'b0, 64'd3, 64'd4, 64'd12, MUL_LAT_D, 0);

    // Flush beats a simultaneous request in IDLE
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; md = MD_DIVU; a = 64'd1; b = 64'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'd0);

    // Flush beats out_ready in DONE
    @(negedge clk);
    in_valid = 1'b1; md = MD_DIVU; a = 64'd100; b = 64'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("done_v", 64'(out_valid), 64'd1);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done_v", 64'(out_valid), 64'd0);
    check("flush_done_rdy", 64'(in_ready), 64'd1);

    // Reset mid-BUSY together with a new request
    @(negedge clk);
    in_valid = 1'b1; md = MD_DIV; a = 64'd1000; b = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_v", 64'(out_valid), 64'd0);
    check("midrst_c", c, 64'd0);
    check("midrst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_noacc", 64'(busy), 64'd0);
    run_op("rem_17/5", MD_REMU, 1'b0, 64'd17, 64'd5, 64'd2, LAT_D, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
